uart_mmio_bridge: RTL and testbench

//  Memory-mapped register front end for the UART in the IO echo system. Sits between the
//  ARC datapath's IO bus and the uart block's FIFO port (rd_uart/wr_uart/r_data/w_data).

---
 rtl/uart_mmio_bridge.sv | 271 +++++++++++++++++++++++++++
 tb/tb_uart_mmio_bridge.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_bridge.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_mmio_bridge
//
// Memory-mapped register front end for the UART in the IO echo system. It sits
// between the CPU IO bus and the UART FIFO port. Each accepted CPU request
// becomes at most one single-cycle FIFO pop or push strobe. DATA accesses block
// while the FIFO is not ready, and abort with err after TIMEOUT wait cycles.
// STATUS reports and clears a sticky error flag. CONTROL enables a registered
// interrupt request.
//
// Register map (i_addr):
//   0 DATA     read pops the RX FIFO, write pushes the TX FIFO
//   1 STATUS   read {5'b0, err_sticky, tx_full, rx_empty}, clears err_sticky
//   2 CONTROL  bit0 rx_irq_en, bit1 tx_irq_en (read/write)
//   3 ID       read returns the ID parameter
//
// Ports:
//   i_clk       system clock, all state updates on the rising edge
//   i_rst_n     asynchronous reset, active low
//   i_req       CPU request strobe, sampled only while o_busy=0
//   i_we        1 = write, 0 = read (qualified by i_req)
//   i_addr      register address
//   i_wdata     write data (qualified by i_req & i_we)
//   o_rdata     read data, valid with o_ack and held until the next read ack
//   o_ack       one-cycle completion pulse
//   o_err       high with o_ack when a DATA access timed out
//   o_busy      high while a request is pending or o_ack is high
//   o_irq       registered interrupt request
//   o_rd_uart   one-cycle RX FIFO pop strobe
//   o_wr_uart   one-cycle TX FIFO push strobe
//   o_w_data    TX byte, valid while o_wr_uart=1
//   i_tx_full   TX FIFO full flag
//   i_rx_empty  RX FIFO empty flag
//   i_r_data    RX FIFO head byte
// -----------------------------------------------------------------------------
module uart_mmio_bridge #(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [7:0]  ID      = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req,
  input  logic       i_we,
  input  logic [1:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata,
  output logic       o_ack,
  output logic       o_err,
  output logic       o_busy,
  output logic       o_irq,
  output logic       o_rd_uart,
  output logic       o_wr_uart,
  output logic [7:0] o_w_data,
  input  logic       i_tx_full,
  input  logic       i_rx_empty,
  input  logic [7:0] i_r_data
);

  // The wait counter only has to reach TIMEOUT-1, so it is sized for that.
  // With TIMEOUT=0 the counter is allowed to wrap because the timeout check
  // is disabled entirely.
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_RX = 2'd1,
    S_WAIT_TX = 2'd2
  } state_t;

  state_t        r_state;
  logic [7:0]    r_rdata;
  logic [7:0]    r_w_data;
  logic [7:0]    r_wbuf;
  logic          r_ack;
  logic          r_err;
  logic          r_rd_uart;
  logic          r_wr_uart;
  logic          r_irq;
  logic [1:0]    r_ctrl;
  logic          r_err_sticky;
  logic [CW-1:0] r_cnt;

  state_t        w_state_nxt;
  logic [7:0]    w_rdata_nxt;
  logic [7:0]    w_w_data_nxt;
  logic [7:0]    w_wbuf_nxt;
  logic          w_ack_nxt;
  logic          w_err_nxt;
  logic          w_rd_nxt;
  logic          w_wr_nxt;
  logic          w_irq_nxt;
  logic [1:0]    w_ctrl_nxt;
  logic          w_sticky_nxt;
  logic [CW-1:0] w_cnt_nxt;

  logic          w_busy;
  logic          w_accept;
  logic          w_timeout;
  logic [7:0]    w_status;

  // Busy covers the ack cycle too. This forces a one-cycle gap between
  // back-to-back requests so the FIFO flags can settle after a strobe.
  assign w_busy    = (r_state != S_IDLE) | r_ack;
  assign w_accept  = i_req & ~w_busy;
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
  assign w_status  = {5'b00000, r_err_sticky, i_tx_full, i_rx_empty};

  // Next-state and next-output logic for the request FSM. Completion is
  // always registered: the edge that completes an access loads ack, the
  // strobe and the data outputs together, and they all drop one cycle later
  // because the pulse outputs default to zero here. In a wait state the
  // FIFO flag is checked before the timeout, so a FIFO that becomes ready on
  // the last wait cycle still completes normally.
  always_comb begin
    w_state_nxt  = r_state;
    w_rdata_nxt  = r_rdata;
    w_w_data_nxt = r_w_data;
    w_wbuf_nxt   = r_wbuf;
    w_ctrl_nxt   = r_ctrl;
    w_sticky_nxt = r_err_sticky;
    w_cnt_nxt    = r_cnt;
    w_ack_nxt    = 1'b0;
    w_err_nxt    = 1'b0;
    w_rd_nxt     = 1'b0;
    w_wr_nxt     = 1'b0;
    w_irq_nxt    = (r_ctrl[0] & ~i_rx_empty) | (r_ctrl[1] & ~i_tx_full);

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (i_addr)
            ADDR_DATA: begin
              if (i_we) begin
                if (!i_tx_full) begin
                  w_w_data_nxt = i_wdata;
                  w_wr_nxt     = 1'b1;
                  w_ack_nxt    = 1'b1;
                end else begin
                  w_wbuf_nxt  = i_wdata;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_WAIT_TX;
                end
              end else begin
                if (!i_rx_empty) begin
                  w_rdata_nxt = i_r_data;
                  w_rd_nxt    = 1'b1;
                  w_ack_nxt   = 1'b1;
                end else begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_WAIT_RX;
                end
              end
            end
            ADDR_STATUS: begin
              w_ack_nxt = 1'b1;
              if (!i_we) begin
                w_rdata_nxt  = w_status;
                w_sticky_nxt = 1'b0;
              end
            end
            ADDR_CONTROL: begin
              w_ack_nxt = 1'b1;
              if (i_we) begin
                w_ctrl_nxt = i_wdata[1:0];
              end else begin
                w_rdata_nxt = {6'b000000, r_ctrl};
              end
            end
            default: begin
              w_ack_nxt = 1'b1;
              if (!i_we) begin
                w_rdata_nxt = ID;
              end
            end
          endcase
        end
      end

      S_WAIT_RX: begin
        if (!i_rx_empty) begin
          w_rdata_nxt = i_r_data;
          w_rd_nxt    = 1'b1;
          w_ack_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_rdata_nxt  = 8'h00;
          w_ack_nxt    = 1'b1;
          w_err_nxt    = 1'b1;
          w_sticky_nxt = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      S_WAIT_TX: begin
        if (!i_tx_full) begin
          w_w_data_nxt = r_wbuf;
          w_wr_nxt     = 1'b1;
          w_ack_nxt    = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_IDLE;
        end else if (w_timeout) begin
          w_ack_nxt    = 1'b1;
          w_err_nxt    = 1'b1;
          w_sticky_nxt = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register for the FSM and every registered output. Reset is
  // asynchronous, so a transaction caught in a wait state is simply dropped:
  // no strobe and no ack ever appear for it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_rdata      <= 8'h00;
      r_w_data     <= 8'h00;
      r_wbuf       <= 8'h00;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      r_rd_uart    <= 1'b0;
      r_wr_uart    <= 1'b0;
      r_irq        <= 1'b0;
      r_ctrl       <= 2'b00;
      r_err_sticky <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rdata      <= w_rdata_nxt;
      r_w_data     <= w_w_data_nxt;
      r_wbuf       <= w_wbuf_nxt;
      r_ack        <= w_ack_nxt;
      r_err        <= w_err_nxt;
      r_rd_uart    <= w_rd_nxt;
      r_wr_uart    <= w_wr_nxt;
      r_irq        <= w_irq_nxt;
      r_ctrl       <= w_ctrl_nxt;
      r_err_sticky <= w_sticky_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  assign o_rdata   = r_rdata;
  assign o_w_data  = r_w_data;
  assign o_ack     = r_ack;
  assign o_err     = r_err;
  assign o_rd_uart = r_rd_uart;
  assign o_wr_uart = r_wr_uart;
  assign o_irq     = r_irq;
  assign o_busy    = w_busy;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_mmio_bridge
//
// Self-checking bench for uart_mmio_bridge. The reference model works at the
// transaction level. The FIFO flag for a DATA access is held not-ready for D
// edges after the request is accepted. The expected completion offset is
// then min(D, 16), and the access times out when D > 16. Register contents
// (ctrl, sticky error and held rdata) are tracked as plain variables.
// -----------------------------------------------------------------------------
module tb_uart_mmio_bridge;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_req;
  logic       i_we;
  logic [1:0] i_addr;
  logic [7:0] i_wdata;
  logic [7:0] o_rdata;
  logic       o_ack;
  logic       o_err;
  logic       o_busy;
  logic       o_irq;
  logic       o_rd_uart;
  logic       o_wr_uart;
  logic [7:0] o_w_data;
  logic       i_tx_full;
  logic       i_rx_empty;
  logic [7:0] i_r_data;

  int checks;
  int failures;

  logic [1:0] mCtrl;
  logic       mSticky;
  logic [7:0] mRdata;

  uart_mmio_bridge #(.TIMEOUT(16), .ID(8'hA5)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req      (i_req),
    .i_we       (i_we),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_rdata    (o_rdata),
    .o_ack      (o_ack),
    .o_err      (o_err),
    .o_busy     (o_busy),
    .o_irq      (o_irq),
    .o_rd_uart  (o_rd_uart),
    .o_wr_uart  (o_wr_uart),
    .o_w_data   (o_w_data),
    .i_tx_full  (i_tx_full),
    .i_rx_empty (i_rx_empty),
    .i_r_data   (i_r_data)
  );

  // Free-running 100 MHz clock.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Hard stop so a stuck design can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired got=running exp=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Drives one request and watches it until its ack plus one more cycle.
  // Offsets count edges from the accepting edge (offset 0). For DATA the
  // relevant flag is not-ready at offsets 0..D-1 and ready from offset D on.
  // With noise set, random requests are driven while the DUT is busy.
  task automatic run_txn(input logic we, input logic [1:0] addr, input logic [7:0] wd,
                         input int D, input logic [7:0] rbyte, input bit noise,
                         output int ackOff, output logic errObs, output int nRd, output int nWr,
                         output logic rdAtAck, output logic wrAtAck,
                         output logic [7:0] rdObs, output logic [7:0] wdObs,
                         output int busyLow, output logic postAck, output logic postBusy);
    bit isData;
    bit done;
    isData = (addr == 2'd0);
    ackOff = -1; errObs = 1'b0; nRd = 0; nWr = 0; rdAtAck = 1'b0; wrAtAck = 1'b0;
    rdObs = 8'h00; wdObs = 8'h00; busyLow = 0; postAck = 1'b1; postBusy = 1'b1;
    i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wd;
    if (isData) begin
      if (we) i_tx_full = (D > 0);
      else begin
        i_rx_empty = (D > 0);
        i_r_data   = (D > 0) ? 8'($urandom) : rbyte;
      end
    end
    done = 1'b0;
    for (int o = 0; o <= 24 && !done; o++) begin
      @(posedge i_clk); #1;
      nRd += int'(o_rd_uart);
      nWr += int'(o_wr_uart);
      if (!o_busy) busyLow++;
      if (o_ack) begin
        ackOff = o; errObs = o_err; rdObs = o_rdata; wdObs = o_w_data;
        rdAtAck = o_rd_uart; wrAtAck = o_wr_uart;
        i_req = noise;
        @(posedge i_clk); #1;
        nRd += int'(o_rd_uart);
        nWr += int'(o_wr_uart);
        postAck = o_ack; postBusy = o_busy;
        done = 1'b1;
      end else begin
        i_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise) begin
          i_we = 1'($urandom); i_addr = 2'($urandom); i_wdata = 8'($urandom);
        end
        if (isData) begin
          if (we) i_tx_full = !(o + 1 >= D);
          else if (o + 1 >= D) begin
            i_rx_empty = 1'b0; i_r_data = rbyte;
          end else i_r_data = 8'($urandom);
        end
      end
    end
    i_req = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_addr = 2'd0; i_wdata = 8'h00;
    i_tx_full = 1'b0; i_rx_empty = 1'b1; i_r_data = 8'h00;
    #22;
    checks++;
    if ({o_rdata, o_w_data, o_ack, o_err, o_busy, o_irq, o_rd_uart, o_wr_uart} !== 22'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h exp=0",
               {o_rdata, o_w_data, o_ack, o_err, o_busy, o_irq, o_rd_uart, o_wr_uart});
    end
    @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    mCtrl = 2'b00; mSticky = 1'b0; mRdata = 8'h00;
    checks++;
    if (o_busy !== 1'b0 || o_ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release got=busy%b ack%b exp=busy0 ack0", o_busy, o_ack);
    end
  endtask

  task automatic test_data_write();
    int ao, nr, nw, bl; logic e, ra, wa, pa, pb; logic [7:0] rd, wdo;
    i_rx_empty = 1'b1;
    run_txn(1'b1, 2'd0, 8'h41, 0, 8'h00, 1'b0, ao, e, nr, nw, ra, wa, rd, wdo, bl, pa, pb);
    checks++;
    if (ao !== 0 || e !== 1'b0) begin
      failures++; $display("[TB] FAIL t1_ack got=off%0d err%b exp=off0 err0", ao, e);
    end
    checks++;
    if (nw !== 1 || wa !== 1'b1 || nr !== 0 || wdo !== 8'h41) begin
      failures++;
      $display("[TB] FAIL t1_push got=wr%0d atAck%b rd%0d w_data=%h exp=wr1 atAck1 rd0 w_data=41", nw, wa, nr, wdo);
    end
  endtask

  task automatic test_data_read();
    int ao, nr, nw, bl; logic e, ra, wa, pa, pb; logic [7:0] rd, wdo;
    run_txn(1'b0, 2'd0, 8'h00, 5, 8'h5A, 1'b1, ao, e, nr, nw, ra, wa, rd, wdo, bl, pa, pb);
    mRdata = 8'h5A;
    checks++;
    if (ao !== 5 || e !== 1'b0 || rd !== 8'h5A) begin
      failures++; $display("[TB] FAIL t2_read got=off%0d err%b rdata=%h exp=off5 err0 rdata=5a", ao, e, rd);
    end
    checks++;
    if (nr !== 1 || ra !== 1'b1 || nw !== 0 || bl !== 0) begin
      failures++;
      $display("[TB] FAIL t2_strobe got=rd%0d atAck%b wr%0d busyLow%0d exp=rd1 atAck1 wr0 busyLow0", nr, ra, nw, bl);
    end
    checks++;
    if (pa !== 1'b0 || pb !== 1'b0) begin
      failures++; $display("[TB] FAIL t2_after got=ack%b busy%b exp=ack0 busy0", pa, pb);
    end
  endtask

  task automatic test_timeout();
    int ao, nr, nw, bl; logic e, ra, wa, pa, pb; logic [7:0] rd, wdo;
    i_rx_empty = 1'b0;
    run_txn(1'b1, 2'd0, 8'h77, 99, 8'h00, 1'b0, ao, e, nr, nw, ra, wa, rd, wdo, bl, pa, pb);
    mSticky = 1'b1;
    checks++;
    if (ao !== 16 || e !== 1'b1 || nw !== 0 || nr !== 0) begin
      failures++;
      $display("[TB] FAIL t3_timeout got=off%0d err%b wr%0d rd%0d exp=off16 err1 wr0 rd0", ao, e, nw, nr);
    end
    run_txn(1'b0, 2'd1, 8'h00, 0, 8'h00, 1'b0, ao, e, nr, nw, ra, wa, rd, wdo, bl, pa, pb);
    checks++;
    if (rd !== 8'h06 || e !== 1'b0) begin
      failures++; $display("[TB] FAIL t3_status1 got=%h err%b exp=06 err0", rd, e);
    end
    run_txn(1'b0, 2'd1, 8'h00, 0, 8'h00, 1'b0, ao, e, nr, nw, ra, wa, rd, wdo, bl, pa, pb);
    mSticky = 1'b0; mRdata = 8'h02;
    checks++;
    if (rd !== 8'h02) begin
      failures++; $display("[TB] FAIL t3_status2 got=%h exp=02", rd);
    end
  endtask

  task automatic test_control_irq();
    int ao, nr, nw, bl; logic e, ra, wa, pa, pb; logic [7:0] rd, wdo;
    logic expIrq;
    i_tx_full = 1'b1; i_rx_empty = 1'b1;
    run_txn(1'b1, 2'd2, 8'h01, 0, 8'h00, 1'b0, ao, e, nr, nw, ra, wa, rd, wdo, bl, pa, pb);
    mCtrl = 2'b01;
    @(posedge i_clk); #1;
    i_rx_empty = 1'b0;
    @(posedge i_clk); #1;
    checks++;
    if (o_irq !== 1'b1) begin
      failures++; $display("[TB] FAIL t4_irq_on got=%b exp=1", o_irq);
    end
    for (int k = 0; k < 4; k++) begin
      logic [7:0] cw;
      cw = (k == 3) ? 8'h00 : 8'($urandom);
      run_txn(1'b1, 2'd2, cw, 0, 8'h00, 1'b0, ao, e, nr, nw, ra, wa, rd, wdo, bl, pa, pb);
      mCtrl = cw[1:0];
      for (int c = 0; c < 6; c++) begin
        i_rx_empty = 1'($urandom); i_tx_full = 1'($urandom);
        expIrq = (mCtrl[0] & ~i_rx_empty) | (mCtrl[1] & ~i_tx_full);
        @(posedge i_clk); #1;
        checks++;
        if (o_irq !== expIrq) begin
          failures++; $display("[TB] FAIL irq_ctrl%0d got=%b exp=%b", mCtrl, o_irq, expIrq);
        end
      end
    end
    run_txn(1'b0, 2'd2, 8'h00, 0, 8'h00, 1'b0, ao, e, nr, nw, ra, wa, rd, wdo, bl, pa, pb);
    checks++;
    if (rd !== 8'h00) begin
      failures++; $display("[TB] FAIL t4_ctrl_read got=%h exp=00", rd);
    end
    run_txn(1'b0, 2'd3, 8'h00, 0, 8'h00, 1'b0, ao, e, nr, nw, ra, wa, rd, wdo, bl, pa, pb);
    mRdata = 8'hA5;
    checks++;
    if (rd !== 8'hA5 || ao !== 0) begin
      failures++; $display("[TB] FAIL t4_id got=%h off%0d exp=a5 off0", rd, ao);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] wrSeen, ackSeen;
    i_tx_full = 1'b0;
    i_req = 1'b1; i_we = 1'b1; i_addr = 2'd0; i_wdata = 8'h33;
    for (int k = 0; k < 4; k++) begin
      @(posedge i_clk); #1;
      wrSeen[k] = o_wr_uart; ackSeen[k] = o_ack;
      if (k == 3) i_req = 1'b0;
    end
    @(posedge i_clk); #1;
    checks++;
    if (wrSeen !== 4'b0101 || ackSeen !== 4'b0101) begin
      failures++; $display("[TB] FAIL back_to_back got=wr%b ack%b exp=wr0101 ack0101", wrSeen, ackSeen);
    end
  endtask

  task automatic test_reset_midwait();
    int ao, nr, nw, bl; logic e, ra, wa, pa, pb; logic [7:0] rd, wdo;
    int strobes;
    logic [7:0] rb;
    run_txn(1'b0, 2'd0, 8'h00, 30, 8'h00, 1'b0, ao, e, nr, nw, ra, wa, rd, wdo, bl, pa, pb);
    mSticky = 1'b1; mRdata = 8'h00;
    checks++;
    if (ao !== 16 || e !== 1'b1 || rd !== 8'h00 || nr !== 0) begin
      failures++; $display("[TB] FAIL rd_timeout got=off%0d err%b rdata=%h rd%0d exp=off16 err1 rdata=00 rd0", ao, e, rd, nr);
    end
    run_txn(1'b1, 2'd2, 8'h03, 0, 8'h00, 1'b0, ao, e, nr, nw, ra, wa, rd, wdo, bl, pa, pb);
    i_rx_empty = 1'b1; i_tx_full = 1'b0;
    i_req = 1'b1; i_we = 1'b0; i_addr = 2'd0;
    @(posedge i_clk); #1;
    i_req = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_rdata, o_w_data, o_ack, o_err, o_busy, o_irq, o_rd_uart, o_wr_uart} !== 22'h0) begin
      failures++;
      $display("[TB] FAIL t6_async_reset got=%h exp=0",
               {o_rdata, o_w_data, o_ack, o_err, o_busy, o_irq, o_rd_uart, o_wr_uart});
    end
    i_rx_empty = 1'b0; i_r_data = 8'hC3;
    @(negedge i_clk); i_rst_n = 1'b1;
    mCtrl = 2'b00; mSticky = 1'b0; mRdata = 8'h00;
    strobes = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk); #1;
      strobes += int'(o_rd_uart) + int'(o_ack) + int'(o_busy);
    end
    checks++;
    if (strobes !== 0) begin
      failures++; $display("[TB] FAIL t6_after_release got=%0d events exp=0", strobes);
    end
    rb = 8'($urandom);
    run_txn(1'b0, 2'd0, 8'h00, 2, rb, 1'b0, ao, e, nr, nw, ra, wa, rd, wdo, bl, pa, pb);
    mRdata = rb;
    checks++;
    if (ao !== 2 || rd !== rb || nr !== 1 || e !== 1'b0) begin
      failures++; $display("[TB] FAIL t6_new_read got=off%0d rdata=%h rd%0d err%b exp=off2 rdata=%h rd1 err0", ao, rd, nr, e, rb);
    end
    i_tx_full = 1'b1;
    run_txn(1'b0, 2'd1, 8'h00, 0, 8'h00, 1'b0, ao, e, nr, nw, ra, wa, rd, wdo, bl, pa, pb);
    mRdata = 8'h02;
    checks++;
    if (rd !== 8'h02) begin
      failures++; $display("[TB] FAIL t6_status got=%h exp=02", rd);
    end
  endtask

  task automatic test_random();
    int ao, nr, nw, bl; logic e, ra, wa, pa, pb; logic [7:0] rd, wdo;
    logic we; logic [1:0] addr; logic [7:0] wd, rb; int D, pick; bit noise;
    int expOff, expRd, expWr; logic expErr; logic [7:0] expRdata;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom); addr = 2'($urandom); wd = 8'($urandom); rb = 8'($urandom);
      noise = 1'($urandom);
      pick = $urandom_range(0, 9);
      D = (pick < 4) ? 0 : (pick < 8) ? $urandom_range(1, 8) : (pick == 8) ? 16 : $urandom_range(17, 22);
      i_tx_full = 1'($urandom); i_rx_empty = 1'($urandom);
      expRd = 0; expWr = 0; expErr = 1'b0; expOff = 0; expRdata = mRdata;
      if (addr == 2'd0) begin
        expOff = (D > 16) ? 16 : D;
        expErr = (D > 16);
        if (!expErr) begin
          if (we) expWr = 1; else expRd = 1;
        end
        if (!we) expRdata = expErr ? 8'h00 : rb;
        if (expErr) mSticky = 1'b1;
      end else if (addr == 2'd1) begin
        if (!we) begin
          expRdata = {5'b00000, mSticky, i_tx_full, i_rx_empty};
          mSticky = 1'b0;
        end
      end else if (addr == 2'd2) begin
        if (we) mCtrl = wd[1:0]; else expRdata = {6'b000000, mCtrl};
      end else begin
        if (!we) expRdata = 8'hA5;
      end
      run_txn(we, addr, wd, D, rb, noise, ao, e, nr, nw, ra, wa, rd, wdo, bl, pa, pb);
      mRdata = expRdata;
      checks++;
      if (ao !== expOff || e !== expErr) begin
        failures++; $display("[TB] FAIL rnd%0d_ack got=off%0d err%b exp=off%0d err%b", n, ao, e, expOff, expErr);
      end
      checks++;
      if (nr !== expRd || nw !== expWr || ra !== (expRd == 1) || wa !== (expWr == 1)) begin
        failures++; $display("[TB] FAIL rnd%0d_strobe got=rd%0d wr%0d exp=rd%0d wr%0d", n, nr, nw, expRd, expWr);
      end
      checks++;
      if (rd !== expRdata) begin
        failures++; $display("[TB] FAIL rnd%0d_rdata got=%h exp=%h", n, rd, expRdata);
      end
      if (expWr == 1) begin
        checks++;
        if (wdo !== wd) begin
          failures++; $display("[TB] FAIL rnd%0d_wdata got=%h exp=%h", n, wdo, wd);
        end
      end
      checks++;
      if (bl !== 0 || pa !== 1'b0 || pb !== 1'b0) begin
        failures++; $display("[TB] FAIL rnd%0d_busy got=busyLow%0d postAck%b postBusy%b exp=0 0 0", n, bl, pa, pb);
      end
    end
  endtask

  // Scenario sequence; the summary line is the last thing printed.
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_data_write();
    test_data_read();
    test_timeout();
    test_control_irq();
    test_back_to_back();
    test_reset_midwait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
